// File: rtl/tweak_pkg.sv
// Shared definitions for tweak_seq_core: instruction formats, opcodes,
// FSM states and the bit positions of the instruction register fields.
package tweak_pkg;

    localparam logic [1:0] FMT_SYS = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_RSV = 2'b10;
    localparam logic [1:0] FMT_REG = 2'b11;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_LDI  = 6'h10;
    localparam logic [5:0] OP_BZ   = 6'h20;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // Field positions; register fields are 4 bits wide in the encoding.
    localparam int FMT_LSB = 30;
    localparam int OP_LSB  = 24;
    localparam int RA_LSB  = 0;
    localparam int RB_LSB  = 4;
    localparam int RD_LSB  = 8;
    localparam int IRD_LSB = 20;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 20;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

endpackage

// File: rtl/tweak_seq_alu.sv
// Combinational ALU for register-format instructions; unknown ops pass
// operand a through unchanged.
module tweak_seq_alu
    import tweak_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/tweak_seq_core.sv
// Multi-cycle fetch/decode/execute core with a wait-stated instruction port.
// Define TWEAK_BRANCH_EN to implement the BZ branch; otherwise BZ is a NOP.
module tweak_seq_core
    import tweak_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int NREGS      = 16,
    parameter  int IMEM_DEPTH = 16,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              retire,
    output logic [DATA_W-1:0] result,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    localparam int RIDX_W = $clog2(NREGS);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              req_q, req_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              wr_en;
    logic [RIDX_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NREGS-1:0]  wr_sel;

    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [RIDX_W-1:0] ra_idx, rb_idx, rd_idx, ird_idx;
    logic [31:0]       imm_w;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_y;

    assign fmt     = ir_q[FMT_LSB +: 2];
    assign op      = ir_q[OP_LSB +: 6];
    assign ra_idx  = ir_q[RA_LSB +: RIDX_W];
    assign rb_idx  = ir_q[RB_LSB +: RIDX_W];
    assign rd_idx  = ir_q[RD_LSB +: RIDX_W];
    assign ird_idx = ir_q[IRD_LSB +: RIDX_W];
    assign imm_w   = 32'(ir_q[IMM_LSB +: IMM_W]);
    assign imm_ext = imm_w[DATA_W-1:0];

    tweak_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (op),
        .a_i  (opa_q),
        .b_i  (opb_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        wr_en    = 1'b0;
        wr_idx   = rd_idx;
        wr_data  = alu_y;
        case (state_q)
            ST_FETCH: begin
                // The first FETCH cycle after reset has no request out yet.
                if (req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opa_d = regs_q[ra_idx];
                opb_d = regs_q[rb_idx];
`ifdef TWEAK_BRANCH_EN
                if (fmt == FMT_IMM && op == OP_BZ) begin
                    opa_d = regs_q[ird_idx];
                end
`endif
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (fmt)
                    FMT_REG: begin
                        wr_en    = 1'b1;
                        wr_idx   = rd_idx;
                        wr_data  = alu_y;
                        result_d = alu_y;
                    end
                    FMT_IMM: begin
                        if (op == OP_LDI) begin
                            wr_en    = 1'b1;
                            wr_idx   = ird_idx;
                            wr_data  = imm_ext;
                            result_d = imm_ext;
                        end
`ifdef TWEAK_BRANCH_EN
                        else if (op == OP_BZ && opa_q == '0) begin
                            pc_d = ir_q[PC_W-1:0];
                        end
`endif
                    end
                    FMT_SYS: begin
                        if (op == OP_HALT) begin
                            state_d = ST_HALT;
                        end
                    end
                    default: ;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        // Request is registered so it drops the cycle after acknowledge.
        req_d = (state_d == ST_FETCH);
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wsel
        assign wr_sel[gi] = wr_en && (wr_idx == RIDX_W'(gi));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            req_q    <= 1'b0;
            ir_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            ir_q     <= ir_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign retire    = (state_q == ST_EXEC);
    assign result    = result_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_tweak_seq_core.sv
// Directed bench for tweak_seq_core: a wait-stated memory responder, an ISA
// model feeding a scoreboard of expected retire results, and timing checks.
module tb_tweak_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        retire;
    logic [31:0] result;
    logic [3:0]  pc;
    logic        halted;

    always #5 clk = ~clk;

    tweak_seq_core #(.DATA_W(32), .NREGS(16), .IMEM_DEPTH(16)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .retire    (retire),
        .result    (result),
        .pc        (pc),
        .halted    (halted)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  pc;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [16];
    logic [31:0] mregs [16];
    logic [3:0]  mpc;
    logic [31:0] mres;
    int vectors = 0;
    int miscompares = 0;
    int wait_cfg, wait_left, cyc, first_req_cyc, first_ret_cyc, n_retire;
    bit ret_pending, req_prev, ack_prev;
    logic [3:0] addr_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] rd,
                                          input logic [3:0] ra, input logic [3:0] rb);
        return {2'b11, op, 12'd0, rd, rb, ra};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                          input logic [19:0] imm);
        return {2'b01, op, rd, imm};
    endfunction

    localparam logic [31:0] I_HALT = {2'b00, 6'h3F, 24'd0};
    localparam logic [31:0] I_NOP  = {2'b10, 30'd0};

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 32'(i);
        mpc  = 4'd0;
        mres = 32'd0;
    endtask

    // Reference ISA semantics; pushes what the core must show after retire.
    task automatic model_exec(input logic [31:0] w);
        logic [1:0] f;
        logic [5:0] o;
        logic [31:0] a, b, y;
        logic hlt;
        exp_t e;
        f = w[31:30];
        o = w[29:24];
        hlt = 1'b0;
        mpc = mpc + 4'd1;
        if (f == 2'b11) begin
            a = mregs[w[3:0]];
            b = mregs[w[7:4]];
            case (o)
                6'h00: y = a + b;
                6'h01: y = a - b;
                6'h02: y = a & b;
                6'h03: y = a | b;
                6'h04: y = a ^ b;
                default: y = a;
            endcase
            mregs[w[11:8]] = y;
            mres = y;
        end else if (f == 2'b01 && o == 6'h10) begin
            mregs[w[23:20]] = {12'd0, w[19:0]};
            mres = {12'd0, w[19:0]};
        end else if (f == 2'b01 && o == 6'h20) begin
`ifdef TWEAK_BRANCH_EN
            if (mregs[w[23:20]] == 32'd0) mpc = w[3:0];
`endif
        end else if (f == 2'b00 && o == 6'h3F) begin
            hlt = 1'b1;
        end
        e.res = mres;
        e.pc = mpc;
        e.halt = hlt;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ret_pending) begin
            e = sb.pop_front();
            chk("sb_result", result, e.res);
            chk("sb_pc", 32'(pc), 32'(e.pc));
            chk("sb_halted", 32'(halted), 32'(e.halt));
            ret_pending = 1'b0;
        end
        if (retire) begin
            n_retire++;
            if (first_ret_cyc < 0) first_ret_cyc = cyc;
            if (sb.size() == 0) chk("retire_unexpected", 32'(sb.size()), 32'd1);
            else ret_pending = 1'b1;
        end
        if (req_prev && !ack_prev) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", 32'(imem_addr), 32'(addr_prev));
        end
        if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
        imem_ack = 1'b0;
        if (imem_req) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                model_exec(imem_data);
                wait_left = wait_cfg;
            end
        end
        req_prev  = imem_req;
        ack_prev  = imem_ack;
        addr_prev = imem_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb.delete();
        ret_pending = 1'b0;
        wait_left = wait_cfg;
        req_prev = 1'b0;
        ack_prev = 1'b0;
        first_req_cyc = -1;
        first_ret_cyc = -1;
        n_retire = 0;
    endtask

    task automatic run_until_halt(input int max_cyc);
        for (int i = 0; i < max_cyc && !halted; i++) tick();
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_data = 32'd0;
        wait_cfg = 0;
        cyc = 0;
        for (int i = 0; i < 16; i++) mem[i] = I_NOP;

        // Program: LDI, ADD, SUB, HALT at address 3.
        mem[0] = enc_i(6'h10, 4'd3, 20'h12345);
        mem[1] = enc_r(6'h01 - 6'h01, 4'd5, 4'd1, 4'd2);
        mem[2] = enc_r(6'h01, 4'd6, 4'd1, 4'd2);
        mem[3] = I_HALT;
        do_reset();
        run_until_halt(100);
        chk("zero_wait_latency", 32'(first_ret_cyc - first_req_cyc), 32'd2);
        chk("sub_result", result, 32'hFFFF_FFFF);
        chk("halt_pc", 32'(pc), 32'd4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req || retire) bad++;
        end
        chk("halt_quiet", 32'(bad), 32'd0);

        // Same program with four wait states per fetch.
        wait_cfg = 4;
        do_reset();
        run_until_halt(200);
        chk("wait_latency", 32'(first_ret_cyc - first_req_cyc), 32'd6);
        chk("wait_result", result, 32'hFFFF_FFFF);

        // Branch on zero: LDI R4=0, BZ R4 -> 7.
        wait_cfg = 0;
        for (int i = 0; i < 16; i++) mem[i] = I_HALT;
        mem[0] = enc_i(6'h10, 4'd4, 20'd0);
        mem[1] = enc_i(6'h20, 4'd4, 20'd7);
        do_reset();
        run_until_halt(100);
`ifdef TWEAK_BRANCH_EN
        chk("bz_final_pc", 32'(pc), 32'd8);
`else
        chk("bz_final_pc", 32'(pc), 32'd3);
`endif

        // Straight-line NOPs wrap the pc through 15 -> 0.
        for (int i = 0; i < 16; i++) mem[i] = I_NOP;
        do_reset();
        for (int i = 0; i < 200 && n_retire < 17; i++) tick();
        tick();
        chk("wrap_retires", 32'(n_retire), 32'd17);
        chk("wrap_pc", 32'(pc), 32'd1);

        // Reset lands while a stalled fetch is outstanding.
        do_reset();
        for (int i = 0; i < 50 && n_retire < 2; i++) tick();
        wait_left = 50;
        for (int i = 0; i < 10 && !imem_req; i++) tick();
        tick();
        tick();
        chk("midfetch_req_before", 32'(imem_req), 32'd1);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tweak_seq_core.md
# tweak_seq_core

Parametrised multi-cycle successor to the free-running phase-clocked CPU. It fetches 32-bit instructions over a request/acknowledge port with wait-state support and sequences fetch/decode/execute through an explicit state machine. Decode, register file and ALU share one clock and a synchronous reset. Adds load-immediate, conditional branch and halt. Sits between the instruction ROM (or any wait-stated memory) and downstream debug/trace logic.

## Interface
- DATA_W, 32: register and ALU width; valid range 8..32.
- NREGS, 16: register count; power of two, 2..16; register fields are indexed by their low log2(NREGS) bits.
- IMEM_DEPTH, 16: instruction address space in words; power of two, ≥2; PC_W = log2(IMEM_DEPTH).
- CLK  in  1  single clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until acknowledged.
- imem_addr  out  PC_W  word address of requested instruction (= pc).
- imem_ack  in  1  memory accepts request; imem_data valid in the same cycle.
- imem_data  in  32  instruction word.
- retire  out  1  one-cycle pulse when an instruction completes.
- result  out  DATA_W  last value written to the register file.
- pc  out  PC_W  current program counter.
- halted  out  1  core is in HALT.

## Operation
- Encoding: [31:30] format, [29:24] op. Format 11: ra=[3:0], rb=[7:4], rd=[11:8]. Format 01: rd=[23:20], imm=[19:0]. Formats 00/10 carry no registers.
- Format 11 ops: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR; any other op writes R[ra] to rd (pass-through). Arithmetic is modulo 2^DATA_W; no carry or flags.
- Format 01 ops: 0x10 LDI: R[rd] = imm zero-extended, or truncated to DATA_W. 0x20 BZ: if R[rd]==0 then pc = imm[PC_W-1:0], else pc+1. Other ops are NOPs.
- Format 00 op 0x3F: HALT. All other format 00 and every format 10 instruction are NOPs.
- States: FETCH → DECODE → EXEC → FETCH; EXEC → HALT on HALT. HALT is left only by RESET.
- FETCH: imem_req=1 with imem_addr=pc. In the cycle where imem_ack=1, latch imem_data into IR and go to DECODE. Otherwise stay in FETCH.
- DECODE: latch R[ra] and R[rb] (for BZ, R[rd]) into operand registers.
- EXEC: perform the single register write, if any, and update result. Update pc (pc+1, wrapping at IMEM_DEPTH-1→0, or the branch target). Pulse retire, including for NOP and HALT.
- Register write and operand read never occur in the same cycle, so no bypass is needed. R0 is an ordinary writable register.

## Timing
- Reset values: state=FETCH, pc=0, imem_req=0 in the reset cycle, retire=0, result=0, halted=0, R[i]=i mod 2^DATA_W.
- First imem_req is asserted in the cycle after RESET deasserts.
- Zero-wait memory: 3 cycles per instruction, with retire every third cycle. Each wait cycle adds one.
- imem_addr is stable while imem_req=1. imem_req drops in the cycle after acknowledge. imem_ack is ignored outside FETCH.
- RESET asserted in any state, including mid-fetch with imem_req high, forces the reset values on the next edge. A pending fetch is abandoned, not completed.
- halted rises in the cycle after HALT's EXEC. From then on imem_req stays 0 and retire stays 0.

## Configuration
- TWEAK_BRANCH_EN defined: BZ is implemented as above.
- TWEAK_BRANCH_EN undefined: op 0x20 decodes as a NOP (pc+1, retire still pulses), and the branch comparator and target mux are absent.

## Structure
- Package tweak_pkg: format codes, opcode constants (ADD..XOR, LDI, BZ, HALT), the state enum, and the IR field bit positions.
- One sub-module, tweak_seq_alu: combinational DATA_W-wide ALU taking op, a and b. The FSM, register file and PC stay in tweak_seq_core.

## Test plan
- Reset, then LDI R3=0x12345 with zero-wait memory → retire on cycle 3 after the first imem_req; result=0x12345; pc=1.
- ADD rd=5, ra=1, rb=2 after reset → result=3. SUB rd=6, ra=1, rb=2 → result=0xFFFFFFFF (DATA_W=32).
- imem_ack withheld for 4 cycles → imem_req and imem_addr stay stable; retire comes 4 cycles later than the zero-wait case.
- With TWEAK_BRANCH_EN, LDI R4=0 then BZ R4→7 → pc=7. Same program without the macro → pc=2.
- HALT at address 3 → halted=1, then no further imem_req or retire for 20 cycles. RESET → pc=0 and halted=0.
- IMEM_DEPTH=4 with four NOPs → pc sequence 1,2,3,0. RESET asserted while imem_req is high → imem_req=0 and pc=0 on the next cycle.
